// File: rtl/btb_pkg.sv
// Shared widths, payload types and controller state for the BTB access controller.
package btb_pkg;

  localparam int unsigned BTB_IDX_W     = 4;
  localparam int unsigned BTB_TAG_W     = 8;
  localparam int unsigned BTB_TGT_W     = 16;
  localparam int unsigned BTB_UPD_DEPTH = 2;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] tgt;
  } btb_entry_t;

  typedef struct packed {
    logic [BTB_IDX_W-1:0] idx;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] tgt;
  } btb_upd_t;

  typedef enum logic {
    FLUSH = 1'b0,
    IDLE  = 1'b1
  } btb_ctrl_state_t;

endpackage

// File: rtl/btb_ctrl_if.sv
// Lookup, update and entry-RAM signal bundle between the pipeline, the controller and the BTB RAM.
interface btb_ctrl_if #(
  parameter int unsigned IDX_W = btb_pkg::BTB_IDX_W,
  parameter int unsigned TAG_W = btb_pkg::BTB_TAG_W,
  parameter int unsigned TGT_W = btb_pkg::BTB_TGT_W
);

  logic             lk_req;
  logic [IDX_W-1:0] lk_idx;
  logic             lk_gnt;
  logic             lk_rvalid;

  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [TGT_W-1:0] upd_tgt;
  logic             upd_ready;

  logic                   ram_en;
  logic                   ram_we;
  logic [IDX_W-1:0]       ram_addr;
  logic [TAG_W+TGT_W:0]   ram_wdata;

  modport slave (
    input  lk_req, lk_idx, upd_valid, upd_idx, upd_tag, upd_tgt,
    output lk_gnt, lk_rvalid, upd_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output lk_req, lk_idx, upd_valid, upd_idx, upd_tag, upd_tgt,
    input  lk_gnt, lk_rvalid, upd_ready, ram_en, ram_we, ram_addr, ram_wdata
  );

endinterface

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO holding resolved-branch updates until the entry RAM port is free.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter type          T     = btb_upd_t,
  parameter int unsigned  DEPTH = BTB_UPD_DEPTH,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  T                 din,
  output T                 dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem_q [DEPTH];
  T                 mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[head_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PTR_W'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_d = count_q + CNT_W'(1);
      end else if (!push_ok && pop_ok) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/btb_ctrl.sv
// BTB entry-RAM scheduler: fetch lookups, queued EX updates and a full-table invalidate sweep.
// Optional event counters are built when BTB_CTRL_STATS_EN is defined.
module btb_ctrl
  import btb_pkg::*;
#(
  parameter int unsigned IDX_W     = BTB_IDX_W,
  parameter int unsigned TAG_W     = BTB_TAG_W,
  parameter int unsigned TGT_W     = BTB_TGT_W,
  parameter int unsigned UPD_DEPTH = BTB_UPD_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btb_en,
  input  logic        flush_req,
  output logic        flush_busy,
  btb_ctrl_if.slave   bus
`ifdef BTB_CTRL_STATS_EN
  ,
  output logic [31:0] stat_lk_gnt,
  output logic [31:0] stat_lk_deny,
  output logic [31:0] stat_upd_wr
`endif
);

  localparam int unsigned CNT_W = $clog2(UPD_DEPTH) + 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] tgt;
  } entry_t;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [TGT_W-1:0] tgt;
  } upd_t;

  btb_ctrl_state_t  state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             lk_rvalid_q, lk_rvalid_d;

  logic             ram_en_c;
  logic             ram_we_c;
  logic [IDX_W-1:0] ram_addr_c;
  entry_t           ram_wdata_c;
  logic             lk_gnt_c;
  logic             upd_ready_c;
  logic             lk_want;

  upd_t             fifo_din;
  upd_t             fifo_head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_clear;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign lk_want  = bus.lk_req && btb_en;
  assign fifo_din = '{idx: bus.upd_idx, tag: bus.upd_tag, tgt: bus.upd_tgt};

  btb_upd_fifo #(
    .T     (upd_t),
    .DEPTH (UPD_DEPTH)
  ) u_upd_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (fifo_clear),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Port arbitration: a full queue beats lookups so updates cannot starve.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ram_en_c    = 1'b0;
    ram_we_c    = 1'b0;
    ram_addr_c  = '0;
    ram_wdata_c = '0;
    lk_gnt_c    = 1'b0;
    upd_ready_c = 1'b0;
    fifo_push   = 1'b0;
    fifo_pop    = 1'b0;
    fifo_clear  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FLUSH: begin
          ram_en_c   = 1'b1;
          ram_we_c   = 1'b1;
          ram_addr_c = cnt_q;
          cnt_d      = cnt_q + IDX_W'(1);
          if (cnt_q == {IDX_W{1'b1}}) begin
            state_d = IDLE;
          end
        end
        IDLE: begin
          if (flush_req) begin
            state_d    = FLUSH;
            cnt_d      = '0;
            fifo_clear = 1'b1;
          end else begin
            upd_ready_c = (fifo_count < CNT_W'(UPD_DEPTH));
            // With the BTB disabled updates are acknowledged but dropped.
            fifo_push   = bus.upd_valid && upd_ready_c && btb_en;
            if (fifo_full || (!lk_want && !fifo_empty)) begin
              ram_en_c    = 1'b1;
              ram_we_c    = 1'b1;
              ram_addr_c  = fifo_head.idx;
              ram_wdata_c = '{valid: 1'b1, tag: fifo_head.tag, tgt: fifo_head.tgt};
              fifo_pop    = 1'b1;
            end else if (lk_want) begin
              ram_en_c   = 1'b1;
              ram_addr_c = bus.lk_idx;
              lk_gnt_c   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign lk_rvalid_d = lk_gnt_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FLUSH;
      cnt_q       <= '0;
      lk_rvalid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lk_rvalid_q <= lk_rvalid_d;
    end
  end

  assign flush_busy    = rst || (state_q == FLUSH);
  assign bus.lk_gnt    = lk_gnt_c;
  assign bus.lk_rvalid = lk_rvalid_q && !rst;
  assign bus.upd_ready = upd_ready_c;
  assign bus.ram_en    = ram_en_c;
  assign bus.ram_we    = ram_we_c;
  assign bus.ram_addr  = ram_addr_c;
  assign bus.ram_wdata = ram_wdata_c;

`ifdef BTB_CTRL_STATS_EN
  logic [31:0] st_gnt_q, st_gnt_d;
  logic [31:0] st_deny_q, st_deny_d;
  logic [31:0] st_wr_q, st_wr_d;

  // Saturating event counters; only rst clears them.
  always_comb begin
    st_gnt_d  = st_gnt_q;
    st_deny_d = st_deny_q;
    st_wr_d   = st_wr_q;
    if (lk_gnt_c && (st_gnt_q != '1)) begin
      st_gnt_d = st_gnt_q + 32'd1;
    end
    if (lk_want && !lk_gnt_c && (st_deny_q != '1)) begin
      st_deny_d = st_deny_q + 32'd1;
    end
    if (fifo_pop && (st_wr_q != '1)) begin
      st_wr_d = st_wr_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_gnt_q  <= '0;
      st_deny_q <= '0;
      st_wr_q   <= '0;
    end else begin
      st_gnt_q  <= st_gnt_d;
      st_deny_q <= st_deny_d;
      st_wr_q   <= st_wr_d;
    end
  end

  assign stat_lk_gnt  = st_gnt_q;
  assign stat_lk_deny = st_deny_q;
  assign stat_upd_wr  = st_wr_q;
`endif

endmodule

// File: tb/tb_btb_ctrl.sv
// Self-checking bench for btb_ctrl: directed vector table, hand-written flush/reset sequences
// and a randomized run against a queue-based reference model.
module tb_btb_ctrl;

  localparam int UPD_DEPTH = 2;
  localparam int N_ENTRIES = 16;

  typedef struct packed {
    logic        rst;
    logic        btb_en;
    logic        flush;
    logic        lk_req;
    logic [3:0]  lk_idx;
    logic        uv;
    logic [3:0]  ui;
    logic [7:0]  ut;
    logic [15:0] ug;
  } in_t;

  typedef struct packed {
    logic        en;
    logic        we;
    logic [3:0]  addr;
    logic [24:0] wdata;
    logic        gnt;
    logic        rv;
    logic        rdy;
    logic        busy;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [7:0]  tag;
    logic [15:0] tgt;
  } mupd_t;

  logic clk = 1'b0;
  logic rst;
  logic btb_en;
  logic flush_req;
  logic flush_busy;

  int checks   = 0;
  int failures = 0;

  btb_ctrl_if bus ();

`ifdef BTB_CTRL_STATS_EN
  logic [31:0] stat_lk_gnt;
  logic [31:0] stat_lk_deny;
  logic [31:0] stat_upd_wr;
`endif

  btb_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .btb_en     (btb_en),
    .flush_req  (flush_req),
    .flush_busy (flush_busy),
    .bus        (bus)
`ifdef BTB_CTRL_STATS_EN
    ,
    .stat_lk_gnt  (stat_lk_gnt),
    .stat_lk_deny (stat_lk_deny),
    .stat_upd_wr  (stat_upd_wr)
`endif
  );

  always #5 clk = ~clk;

  // Reference model state: sweep position, pending updates, last grant.
  bit    m_flushing;
  int    m_sweep;
  mupd_t m_q[$];
  bit    m_prev_gnt;

  function automatic in_t mk_in(input logic r, input logic en, input logic fl, input logic lk,
                                input logic [3:0] li, input logic uv, input logic [3:0] ui,
                                input logic [7:0] ut, input logic [15:0] ug);
    in_t v;
    v = '{rst: r, btb_en: en, flush: fl, lk_req: lk, lk_idx: li, uv: uv, ui: ui, ut: ut, ug: ug};
    return v;
  endfunction

  function automatic out_t mk_out(input logic en, input logic we, input logic [3:0] a,
                                  input logic [24:0] wd, input logic g, input logic rv,
                                  input logic rdy, input logic busy);
    out_t v;
    v = '{en: en, we: we, addr: a, wdata: wd, gnt: g, rv: rv, rdy: rdy, busy: busy};
    return v;
  endfunction

  function automatic out_t model_eval(input in_t i);
    out_t e;
    bit   look;
    e    = '0;
    look = i.lk_req && i.btb_en;
    if (i.rst) begin
      e.busy = 1'b1;
      return e;
    end
    e.rv = m_prev_gnt;
    if (m_flushing) begin
      e.busy = 1'b1;
      e.en   = 1'b1;
      e.we   = 1'b1;
      e.addr = 4'(m_sweep);
    end else if (!i.flush) begin
      e.rdy = (m_q.size() < UPD_DEPTH);
      if (m_q.size() == UPD_DEPTH || (!look && m_q.size() > 0)) begin
        e.en    = 1'b1;
        e.we    = 1'b1;
        e.addr  = m_q[0].idx;
        e.wdata = {1'b1, m_q[0].tag, m_q[0].tgt};
      end else if (look) begin
        e.en   = 1'b1;
        e.addr = i.lk_idx;
        e.gnt  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update(input in_t i, input out_t e);
    mupd_t u;
    if (i.rst) begin
      m_flushing = 1'b1;
      m_sweep    = 0;
      m_q.delete();
      m_prev_gnt = 1'b0;
      return;
    end
    m_prev_gnt = e.gnt;
    if (m_flushing) begin
      m_sweep++;
      if (m_sweep == N_ENTRIES) begin
        m_flushing = 1'b0;
        m_sweep    = 0;
      end
    end else if (i.flush) begin
      m_flushing = 1'b1;
      m_sweep    = 0;
      m_q.delete();
    end else begin
      if (e.we) void'(m_q.pop_front());
      if (i.uv && e.rdy && i.btb_en) begin
        u = '{idx: i.ui, tag: i.ut, tgt: i.ug};
        m_q.push_back(u);
      end
    end
  endtask

  // Drive one cycle's inputs after the falling edge and check outputs before the next rising edge.
  task automatic apply(input in_t i, input out_t e, input string nm);
    out_t g;
    @(negedge clk);
    rst           = i.rst;
    btb_en        = i.btb_en;
    flush_req     = i.flush;
    bus.lk_req    = i.lk_req;
    bus.lk_idx    = i.lk_idx;
    bus.upd_valid = i.uv;
    bus.upd_idx   = i.ui;
    bus.upd_tag   = i.ut;
    bus.upd_tgt   = i.ug;
    #1;
    g = '{en: bus.ram_en, we: bus.ram_we, addr: bus.ram_addr, wdata: bus.ram_wdata,
          gnt: bus.lk_gnt, rv: bus.lk_rvalid, rdy: bus.upd_ready, busy: flush_busy};
    checks++;
    if (g !== e) begin
      failures++;
      $display("FAIL %s t=%0t got{en,we,addr,wdata,gnt,rv,rdy,busy}=%0b,%0b,%0d,%h,%0b,%0b,%0b,%0b exp=%0b,%0b,%0d,%h,%0b,%0b,%0b,%0b",
               nm, $time, g.en, g.we, g.addr, g.wdata, g.gnt, g.rv, g.rdy, g.busy,
               e.en, e.we, e.addr, e.wdata, e.gnt, e.rv, e.rdy, e.busy);
    end
  endtask

  task automatic apply_model(input in_t i, input string nm);
    out_t e;
    e = model_eval(i);
    apply(i, e, nm);
    model_update(i, e);
  endtask

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{mk_in(0,1,0,1,4'd1,1,4'd3,8'hA5,16'h0040), mk_out(1,0,4'd1,25'h0,1,0,1,0)};
    tbl[1]  = '{mk_in(0,1,0,1,4'd2,1,4'd4,8'h5A,16'h0080), mk_out(1,0,4'd2,25'h0,1,1,1,0)};
    tbl[2]  = '{mk_in(0,1,0,1,4'd6,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'd3,25'h1A50040,0,1,0,0)};
    tbl[3]  = '{mk_in(0,1,0,1,4'd7,0,4'd0,8'h00,16'h0000), mk_out(1,0,4'd7,25'h0,1,0,1,0)};
    tbl[4]  = '{mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'd4,25'h15A0080,0,1,1,0)};
    tbl[5]  = '{mk_in(0,1,0,0,4'd0,1,4'd8,8'h11,16'h1111), mk_out(0,0,4'd0,25'h0,0,0,1,0)};
    tbl[6]  = '{mk_in(0,1,0,1,4'd9,1,4'd9,8'h22,16'h2222), mk_out(1,0,4'd9,25'h0,1,0,1,0)};
    tbl[7]  = '{mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'd8,25'h1111111,0,1,0,0)};
    tbl[8]  = '{mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'd9,25'h1222222,0,0,1,0)};
    tbl[9]  = '{mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(0,0,4'd0,25'h0,0,0,1,0)};
    tbl[10] = '{mk_in(0,0,0,1,4'd2,1,4'hA,8'h33,16'h3333), mk_out(0,0,4'd0,25'h0,0,0,1,0)};
    tbl[11] = '{mk_in(0,0,0,1,4'd3,1,4'hB,8'h44,16'h4444), mk_out(0,0,4'd0,25'h0,0,0,1,0)};
    tbl[12] = '{mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(0,0,4'd0,25'h0,0,0,1,0)};

    rst = 1'b1; btb_en = 1'b1; flush_req = 1'b0;
    bus.lk_req = 1'b0; bus.lk_idx = '0; bus.upd_valid = 1'b0;
    bus.upd_idx = '0; bus.upd_tag = '0; bus.upd_tgt = '0;

    // Reset, then the automatic sweep with lookups and updates held off.
    for (int k = 0; k < 3; k++)
      apply(mk_in(1,1,0,1,4'd5,1,4'd1,8'h01,16'h0001), mk_out(0,0,4'd0,25'h0,0,0,0,1), "reset");
    for (int k = 0; k < N_ENTRIES; k++)
      apply(mk_in(0,1,0,1,4'd5,1,4'd1,8'h01,16'h0001), mk_out(1,1,4'(k),25'h0,0,0,0,1), "boot_sweep");

    for (int n = 0; n < 13; n++)
      apply(tbl[n].i, tbl[n].o, $sformatf("vec%0d", n));

    // Flush drops a queued update; a repeated request mid-sweep does not extend it.
    apply(mk_in(0,1,0,1,4'd0,1,4'd5,8'h77,16'h7777), mk_out(1,0,4'd0,25'h0,1,0,1,0), "fl_queue");
    apply(mk_in(0,1,1,1,4'd1,1,4'd6,8'h78,16'h7878), mk_out(0,0,4'd0,25'h0,0,1,0,0), "fl_req");
    for (int k = 0; k < N_ENTRIES; k++)
      apply(mk_in(0,1,(k == 3),0,4'd0,1,4'd6,8'h78,16'h7878), mk_out(1,1,4'(k),25'h0,0,0,0,1), "fl_sweep");
    for (int k = 0; k < 2; k++)
      apply(mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(0,0,4'd0,25'h0,0,0,1,0), "fl_dropped");

    // Reset at sweep index 7 restarts the sweep from index 0.
    apply(mk_in(0,1,1,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(0,0,4'd0,25'h0,0,0,0,0), "rs_req");
    for (int k = 0; k < 7; k++)
      apply(mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'(k),25'h0,0,0,0,1), "rs_pre");
    for (int k = 0; k < 2; k++)
      apply(mk_in(1,1,0,1,4'd2,1,4'd2,8'h02,16'h0002), mk_out(0,0,4'd0,25'h0,0,0,0,1), "rs_mid");
    for (int k = 0; k < N_ENTRIES; k++)
      apply(mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(1,1,4'(k),25'h0,0,0,0,1), "rs_sweep");
    apply(mk_in(0,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), mk_out(0,0,4'd0,25'h0,0,0,1,0), "rs_idle");

    // Randomized traffic against the reference model.
    apply_model(mk_in(1,1,0,0,4'd0,0,4'd0,8'h00,16'h0000), "rand_rst");
    for (int n = 0; n < 1500; n++) begin
      in_t r;
      r        = '0;
      r.rst    = ($urandom_range(199, 0) == 0);
      r.btb_en = ($urandom_range(7, 0) != 0);
      r.flush  = ($urandom_range(39, 0) == 0);
      r.lk_req = ($urandom_range(1, 0) == 1);
      r.lk_idx = 4'($urandom);
      r.uv     = ($urandom_range(1, 0) == 1);
      r.ui     = 4'($urandom);
      r.ut     = 8'($urandom);
      r.ug     = 16'($urandom);
      apply_model(r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
Access controller and scheduler for the branch target buffer's single-port entry RAM inside the CPU.
- Arbitrates each cycle between three sources:
  - fetch-stage lookups;
  - queued execute-stage update writes, from resolved branches;
  - a full-table invalidate sweep.
- Owns the BTB enable gating and runs an automatic flush out of reset.
- Sits between IF/EX stages and the BTB entry RAM (1-cycle read latency).

Parameters:
- IDX_W, 4, entry index width (2^IDX_W entries).
- TAG_W, 8, tag width.
- TGT_W, 16, branch target width.
- UPD_DEPTH, 2, update FIFO depth (power of 2, ≥2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btb_en  in  1  BTB enable (config).
- flush_req  in  1  one-cycle flush request pulse.
- flush_busy  out  1  sweep in progress.
- lk_req  in  1  fetch lookup request.
- lk_idx  in  IDX_W  lookup index.
- lk_gnt  out  1  lookup granted this cycle.
- lk_rvalid  out  1  ram_rdata holds a granted lookup result (1 cycle after lk_gnt).
- upd_valid  in  1  update request.
- upd_idx  in  IDX_W  update index.
- upd_tag  in  TAG_W  update tag.
- upd_tgt  in  TGT_W  update target.
- upd_ready  out  1  update accepted when upd_valid & upd_ready.
- ram_en  out  1  RAM access strobe.
- ram_we  out  1  RAM write.
- ram_addr  out  IDX_W  RAM index.
- ram_wdata  out  1+TAG_W+TGT_W  {valid, tag, target}.

Behaviour:
- Reset is synchronous, active-high. One clock, clk.
- While rst is high:
  - ram_en, ram_we, lk_gnt, lk_rvalid and upd_ready are 0;
  - ram_addr and ram_wdata are 0;
  - FIFO is empty, sweep counter is 0, state is FLUSH, flush_busy is 1.
- FSM has two states: FLUSH and IDLE.
- FLUSH:
  - Each cycle: ram_en=1, ram_we=1, ram_addr=counter, ram_wdata=0, then counter increments.
  - After writing index 2^IDX_W-1, state becomes IDLE; flush_busy deasserts the next cycle.
  - flush_busy is high for exactly 2^IDX_W cycles.
  - lk_gnt=0 and upd_ready=0 throughout.
  - flush_req is ignored while in FLUSH.
- IDLE:
  - flush_req=1: state becomes FLUSH next cycle, counter is 0, FIFO is cleared (stale updates dropped). No RAM access that cycle; lk_gnt=0. An upd_valid in that cycle is not accepted.
  - Otherwise the priority order is:
    1. FIFO full: write head entry; lk_gnt=0 (anti-starvation).
    2. lk_req & btb_en: ram_en=1, ram_we=0, ram_addr=lk_idx, lk_gnt=1.
    3. FIFO non-empty: write head, with ram_wdata={1, tag, tgt}, then pop.
    4. Else: ram_en=0.
- lk_rvalid is lk_gnt registered by one cycle. A denied lookup is treated by fetch as not-taken.
- upd_ready = !full, from the registered count, in IDLE.
- Push and pop in the same cycle leave the count unchanged. Head/tail pointers wrap modulo UPD_DEPTH.
- btb_en=0:
  - lookups are never granted;
  - updates are accepted (upd_ready=1 in IDLE) and discarded, not pushed;
  - entries already queued still drain;
  - flush is unaffected.
- A lookup and an update to the same index in the same cycle are not forwarded: the lookup returns the pre-write entry.
- rst mid-flush restarts the sweep at index 0.

Optional Feature:
- Macro BTB_CTRL_STATS_EN.
- When defined, adds three outputs, each 32 bits: stat_lk_gnt, stat_lk_deny, stat_upd_wr.
  - stat_lk_gnt counts granted lookups.
  - stat_lk_deny counts cycles with lk_req & btb_en & !lk_gnt.
  - stat_upd_wr counts RAM update writes (flush writes excluded).
  - All three saturate at 2^32-1, are cleared by rst, and are not cleared by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Package btb_pkg holds:
  - IDX_W/TAG_W/TGT_W defaults;
  - typedef btb_entry_t (packed valid/tag/target);
  - typedef btb_upd_t (idx/tag/tgt);
  - enum btb_ctrl_state_t {FLUSH, IDLE}.
- One natural sub-module, btb_upd_fifo: parameterised synchronous FIFO of btb_upd_t, with push/pop/clear/full/empty/count.

Test Plan:
- Reset release → flush_busy=1 for 16 cycles. RAM writes hit indices 0..15 with wdata=0, one per cycle. Then IDLE, with upd_ready=1.
- btb_en=1, lk_req every cycle, push 1 update {idx 3, tag 0xA5, tgt 0x0040} → update waits. Push a second update {idx 4} → FIFO full. Next cycle writes idx 3 with wdata={1,0xA5,0x0040} and lk_gnt=0. Then lookups resume.
- lk_req=0 with 2 queued updates → written on 2 consecutive cycles in FIFO order. upd_ready returns to 1 after the first pop.
- btb_en=0, lk_req=1, upd_valid=1 → lk_gnt=0, upd_ready=1, no ram_we, FIFO count stays 0.
- flush_req with 1 queued update → FIFO cleared, 16 zero writes, queued update never written. A second flush_req during the sweep is ignored (still 16 cycles total).
- rst asserted at sweep index 7 → outputs go to reset values. After release, the sweep restarts at index 0 and runs 16 cycles.
